// File: rtl/fetch_unit.sv
// Purpose : MIPS fetch stage. It owns PCF, drives the instruction memory
//           address, and queues returned words for decode.
// Latency : a word accepted at edge N is at the head, with ValidD=1, in the cycle after N.
// Backpr. : when the queue is full, ImemReady is ignored and PCF holds, so the
//           same address is fetched again. StallD holds the head in place.
// Ports   : CLK/Reset (sync, active-high); ImemAddr/ImemReady/ImemRD to memory;
//           InstrD/PCD/PCPlus4D/ValidD/StallD to decode; RedirectE/RedirectTargetE from execute.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [31:0] ImemAddr,
  input  logic        ImemReady,
  input  logic [31:0] ImemRD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  input  logic        StallD,
  input  logic        RedirectE,
  input  logic [31:0] RedirectTargetE
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  fq_entry_t       q_mem [DEPTH];
  fq_entry_t       head;
  logic [31:0]     pcf;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            accept;
  logic            pop;

  // Full is taken from the registered count. A pop in the same cycle does
  // not free a slot for this cycle's push.
  assign full   = (count == CW'(DEPTH));
  assign accept = ImemReady && !full && !RedirectE;
  assign pop    = ValidD && !StallD && !RedirectE;

  assign ImemAddr = pcf;
  assign ValidD   = (count != '0);
  assign head     = q_mem[rd_ptr];

  // An empty queue presents zeros, so decode sees a nop bubble.
  always_comb begin
    InstrD   = '0;
    PCD      = '0;
    PCPlus4D = '0;
    if (ValidD) begin
      InstrD   = head.instr;
      PCD      = head.pc;
      PCPlus4D = head.pc + 32'd4;
    end
  end

  // Redirect flushes the queue and takes priority over push and pop.
  // DEPTH is a power of two, so the pointers wrap on their natural width.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      pcf    <= RESET_PC & ~32'h3;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (RedirectE) begin
      pcf    <= RedirectTargetE & ~32'h3;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        pcf    <= pcf + 32'd4;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset. Stale entries are never presented because
  // ValidD gates the head outputs.
  always_ff @(posedge CLK) begin
    if (accept && !Reset) begin
      q_mem[wr_ptr] <= '{pc: pcf, instr: ImemRD};
    end
  end

endmodule
